wb_wport_arbiter: RTL and testbench
===================================

// Module: wb_wport_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline WB stage and one
//  long-latency result source (mul/div or uncached-load return). Pipeline WB always wins; losing
//  results wait in a small in-order pending queue with valid/ready backpressure. Queued values are
//  forwarded to decode, and a younger pipeline write to the same register kills the stale entry.
//  Sits between the wb stage mux output and the regfile write port.
// PARAMETERS
//  DEPTH  2   pending-queue entries (power of 2, >=2)
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-high reset
//  pipe_we       in   1   WB-stage regwrite
//  pipe_waddr    in   5   WB-stage destination register
//  pipe_wdata    in   32  WB-stage write data (wb mux output)
//  lu_valid      in   1   long-latency result valid
//  lu_ready      out  1   arbiter can accept lu result this cycle
//  lu_waddr      in   5   long-latency destination register
//  lu_wdata      in   32  long-latency result data
//  rf_we         out  1   regfile write enable
//  rf_waddr      out  5   regfile write address
//  rf_wdata      out  32  regfile write data
//  rd_addr_a/b   in   5   decode source registers for forwarding lookup
//  fwd_hit_a/b   out  1   source matches a valid queued entry
//  fwd_data_a/b  out  32  data of youngest matching valid entry
//  pend_cnt      out  $clog2(DEPTH+1)  queue occupancy (incl. killed entries)
// BEHAVIOUR
//  - One clock, synchronous active-high reset: rst=1 empties queue, clears all entry valid bits,
//    pointers=0, pend_cnt=0; while rst=1 rf_we=0, lu_ready=0, fwd_hit_a/b=0, rf_waddr/rf_wdata=0.
//  - Write port is combinational, same cycle. Priority: (1) pipe_we && pipe_waddr!=0;
//    (2) valid queue head (pop); (3) lu bypass when queue empty and lu_valid && lu_ready.
//  - lu_ready = (pend_cnt<DEPTH); combinational from registered count, not from lu_valid.
//  - Handshake lu_valid&&lu_ready: lu_waddr==0 -> consumed, no write, no enqueue; bypassed if port
//    free and queue empty; otherwise enqueued at tail. Same-cycle pop and push both allowed when full
//    only if pop happens first? No: when full lu_ready=0, no push regardless of pop.
//  - Ordering: queue entries and lu results are always older than the current WB instruction.
//    pipe write to reg X clears valid of every queued entry with waddr==X, and a same-cycle accepted
//    lu result with waddr==X is consumed and dropped.
//  - Killed (invalid) head entry is popped without using the port, even when pipe_we=1; at most one
//    pop per cycle.
//  - Forwarding: combinational; address 0 never hits; youngest valid match wins; entry killed this
//    cycle still forwards this cycle (kill takes effect next edge).
//  - Pointers wrap modulo DEPTH; pend_cnt saturates never (push blocked at DEPTH, pop blocked at 0).
//  - Reset mid-operation discards queued results; no regfile write of them ever occurs.
// STRUCTURE
//  - cpu_defs.svh: typedef struct packed {logic we; logic [4:0] waddr; logic [31:0] wdata;} wb_req_t;
//    localparam REG_ZERO = 5'd0.
//  - Sub-module wb_pend_fifo: entry array, valid bits, head/tail pointers, kill-by-address and CAM
//    forwarding lookup; arbiter top holds priority mux and handshake only.
// TESTING
//  1. rst=1 two cycles -> rf_we=0, lu_ready=0, pend_cnt=0; rst=0 -> lu_ready=1.
//  2. Pipe idle, lu r5=0xDEADBEEF -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, pend_cnt stays 0.
//  3. Pipe writes r3 three cycles; lu sends r7=0x7, r8=0x8, r9 -> r7,r8 queued, lu_ready=0 on third;
//     pipe idle -> r7 then r8 written on consecutive cycles, then r9 accepted.
//  4. Queue holds r9=0x11; pipe writes r9=0x22 -> entry killed, popped silently; r9 ends 0x22.
//  5. Queue r4=0xAA then r4=0xBB; rd_addr_a=4 -> fwd_hit_a=1, fwd_data_a=0xBB; rd_addr_b=0 -> hit 0.
//  6. lu_waddr=0 accepted -> no rf_we, no enqueue; rst asserted with 2 queued -> neither ever written.

Source files
------------

// File: rtl/wb_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_wport_arbiter_pkg;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A write request only touches the regfile when it targets a non-zero register.
    function automatic logic is_live_write(wb_req_t req);
        return req.we && (req.waddr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// In-order pending queue of long-latency results with kill-by-address and forwarding lookup.
module wb_pend_fifo
    import wb_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [4:0]                   push_waddr,
    input  logic [31:0]                  push_wdata,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [4:0]                   kill_waddr,
    input  logic [4:0]                   rd_addr_a,
    input  logic [4:0]                   rd_addr_b,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         fwd_hit_a,
    output logic [31:0]                  fwd_data_a,
    output logic                         fwd_hit_b,
    output logic [31:0]                  fwd_data_b
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Entry .we doubles as the valid bit; slots outside the occupied range are always invalid.
    wb_req_t        entry_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && entry_q[i].waddr == kill_waddr) begin
                    entry_q[i].we <= 1'b0;
                end
            end
            if (pop) begin
                entry_q[head_q].we <= 1'b0;
                head_q             <= head_q + 1'b1;
            end
            if (push) begin
                entry_q[tail_q] <= '{we: 1'b1, waddr: push_waddr, wdata: push_wdata};
                tail_q          <= tail_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = entry_q[head_q];
    assign count = count_q;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!rst && entry_q[idx].we && entry_q[idx].waddr != REG_ZERO) begin
                if (entry_q[idx].waddr == rd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = entry_q[idx].wdata;
                end
                if (entry_q[idx].waddr == rd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = entry_q[idx].wdata;
                end
            end
        end
    end

endmodule

// File: rtl/wb_wport_arbiter.sv
// Shares the regfile write port between the WB stage (always wins) and a long-latency result source.
module wb_wport_arbiter
    import wb_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_we,
    input  logic [4:0]                   pipe_waddr,
    input  logic [31:0]                  pipe_wdata,
    input  logic                         lu_valid,
    output logic                         lu_ready,
    input  logic [4:0]                   lu_waddr,
    input  logic [31:0]                  lu_wdata,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    input  logic [4:0]                   rd_addr_a,
    input  logic [4:0]                   rd_addr_b,
    output logic                         fwd_hit_a,
    output logic [31:0]                  fwd_data_a,
    output logic                         fwd_hit_b,
    output logic [31:0]                  fwd_data_b,
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t        pipe_req;
    wb_req_t        head;
    wb_req_t        wr;
    logic [CW-1:0]  count;
    logic           pipe_act;
    logic           q_empty;
    logic           lu_fire;
    logic           lu_drop;
    logic           pop;
    logic           bypass;
    logic           push;

    assign pipe_req = '{we: pipe_we, waddr: pipe_waddr, wdata: pipe_wdata};
    assign pipe_act = is_live_write(pipe_req);
    assign q_empty  = (count == '0);
    assign lu_ready = !rst && (count < CW'(DEPTH));
    assign lu_fire  = lu_valid && lu_ready;

    // An lu result is older than the WB instruction, so a same-register pipe write supersedes it.
    assign lu_drop  = (lu_waddr == REG_ZERO) || (pipe_act && lu_waddr == pipe_waddr);

    // Killed heads retire without the port, so they may pop even while WB writes.
    assign pop      = !rst && !q_empty && (!head.we || !pipe_act);
    assign bypass   = lu_fire && !lu_drop && q_empty && !pipe_act;
    assign push     = lu_fire && !lu_drop && !bypass;

    always_comb begin
        wr = '0;
        if (!rst) begin
            if (pipe_act) begin
                wr = pipe_req;
            end else if (pop && head.we) begin
                wr = head;
            end else if (bypass) begin
                wr = '{we: 1'b1, waddr: lu_waddr, wdata: lu_wdata};
            end
        end
    end

    assign rf_we    = wr.we;
    assign rf_waddr = wr.waddr;
    assign rf_wdata = wr.wdata;
    assign pend_cnt = count;

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_waddr (lu_waddr),
        .push_wdata (lu_wdata),
        .pop        (pop),
        .kill       (pipe_act),
        .kill_waddr (pipe_waddr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .head       (head),
        .count      (count),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_data_a (fwd_data_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_b (fwd_data_b)
    );

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Directed bench: expected regfile writes go to a scoreboard queue checked by a write monitor.
module tb_wb_wport_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;
    logic [1:0]  pend_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [36:0] exp_q [$];

    wb_wport_arbiter #(
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_data_a (fwd_data_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_b (fwd_data_b),
        .pend_cnt   (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rf_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL rf_write: got r%0d=%h, required r%0d=%h",
                             rf_waddr, rf_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we    = pwe;
        pipe_waddr = pa;
        pipe_wdata = pd;
        lu_valid   = lv;
        lu_waddr   = la;
        lu_wdata   = ld;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        // Offered lu result during reset must not be bypassed
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h1111);
        to_neg();
        to_next();
        to_neg();
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_lu_ready", {31'b0, lu_ready}, 32'd0);
        chk("rst_pend_cnt", {30'b0, pend_cnt}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        to_next();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        to_neg();
        chk("post_rst_lu_ready", {31'b0, lu_ready}, 32'd1);
        to_next();

        // Bypass when pipe idle and queue empty
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        to_neg();
        chk("bypass_lu_ready", {31'b0, lu_ready}, 32'd1);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        to_neg();
        chk("bypass_pend_cnt", {30'b0, pend_cnt}, 32'd0);
        to_next();

        // Pipe hogs the port, queue fills, then drains in order
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h7);
        expect_wr(5'd3, 32'h33);
        to_neg();
        to_next();
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd8, 32'h8);
        expect_wr(5'd3, 32'h34);
        to_neg();
        chk("fill_pend_1", {30'b0, pend_cnt}, 32'd1);
        to_next();
        drive(1'b1, 5'd3, 32'h35, 1'b1, 5'd9, 32'h9);
        expect_wr(5'd3, 32'h35);
        to_neg();
        chk("full_pend_2", {30'b0, pend_cnt}, 32'd2);
        chk("full_lu_ready", {31'b0, lu_ready}, 32'd0);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9);
        expect_wr(5'd7, 32'h7);
        to_neg();
        chk("drain_lu_ready_0", {31'b0, lu_ready}, 32'd0);
        to_next();
        expect_wr(5'd8, 32'h8);
        to_neg();
        chk("drain_lu_ready_1", {31'b0, lu_ready}, 32'd1);
        chk("drain_pend_1", {30'b0, pend_cnt}, 32'd1);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd9, 32'h9);
        to_neg();
        chk("drain_r9_pend", {30'b0, pend_cnt}, 32'd1);
        to_next();
        to_neg();
        chk("drained_pend", {30'b0, pend_cnt}, 32'd0);
        to_next();

        // Younger pipe write kills queued entry; killed head pops silently even with pipe active
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h11);
        expect_wr(5'd1, 32'h1);
        to_neg();
        to_next();
        drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
        rd_addr_a = 5'd9;
        expect_wr(5'd9, 32'h22);
        to_neg();
        chk("kill_same_cycle_hit", {31'b0, fwd_hit_a}, 32'd1);
        chk("kill_same_cycle_data", fwd_data_a, 32'h11);
        to_next();
        drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd2, 32'h2);
        to_neg();
        chk("killed_no_hit", {31'b0, fwd_hit_a}, 32'd0);
        chk("killed_pend", {30'b0, pend_cnt}, 32'd1);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rd_addr_a = 5'd0;
        to_neg();
        chk("killed_popped", {30'b0, pend_cnt}, 32'd0);
        to_next();

        // Forwarding picks youngest match; address 0 never hits
        drive(1'b1, 5'd1, 32'h10, 1'b1, 5'd4, 32'hAA);
        expect_wr(5'd1, 32'h10);
        to_neg();
        to_next();
        drive(1'b1, 5'd2, 32'h20, 1'b1, 5'd4, 32'hBB);
        expect_wr(5'd2, 32'h20);
        to_neg();
        to_next();
        drive(1'b1, 5'd6, 32'h60, 1'b0, 5'd0, 32'h0);
        rd_addr_a = 5'd4;
        rd_addr_b = 5'd0;
        expect_wr(5'd6, 32'h60);
        to_neg();
        chk("fwd_hit_a", {31'b0, fwd_hit_a}, 32'd1);
        chk("fwd_data_a_youngest", fwd_data_a, 32'hBB);
        chk("fwd_hit_b_zero", {31'b0, fwd_hit_b}, 32'd0);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rd_addr_a = 5'd0;
        expect_wr(5'd4, 32'hAA);
        to_neg();
        to_next();
        expect_wr(5'd4, 32'hBB);
        to_neg();
        to_next();
        // Same-cycle lu result to the pipe's register is dropped
        drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd12, 32'h99);
        expect_wr(5'd12, 32'hC);
        to_neg();
        chk("drop_lu_ready", {31'b0, lu_ready}, 32'd1);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        to_neg();
        chk("drop_pend", {30'b0, pend_cnt}, 32'd0);
        to_next();

        // r0 lu result consumed without write or enqueue
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        to_neg();
        chk("r0_lu_ready", {31'b0, lu_ready}, 32'd1);
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        to_neg();
        chk("r0_pend", {30'b0, pend_cnt}, 32'd0);
        to_next();

        // Reset with two queued results: neither may ever be written
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA);
        expect_wr(5'd1, 32'h1);
        to_neg();
        to_next();
        drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd11, 32'hB);
        expect_wr(5'd1, 32'h2);
        to_neg();
        to_next();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rd_addr_a = 5'd10;
        rst = 1'b1;
        to_neg();
        chk("midrst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("midrst_lu_ready", {31'b0, lu_ready}, 32'd0);
        chk("midrst_fwd_hit", {31'b0, fwd_hit_a}, 32'd0);
        to_next();
        to_neg();
        chk("midrst_pend", {30'b0, pend_cnt}, 32'd0);
        to_next();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            to_next();
        end
        to_neg();
        chk("final_pend", {30'b0, pend_cnt}, 32'd0);
        chk("final_fwd_hit", {31'b0, fwd_hit_a}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
